// File: rtl/lfsr_seq_engine_pkg.sv
// ============================================================================
// lfsr_seq_engine_pkg
// Shared constants and the next-state function for the LFSR sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lfsr_seq_engine_pkg;

  localparam logic MODE_GALOIS = 1'b0;
  localparam logic MODE_FIB    = 1'b1;
  localparam int   c_MAX_WIDTH = 16;

  // Operates on a zero-extended c_MAX_WIDTH vector; only the low `width` bits are meaningful.
  function automatic logic [c_MAX_WIDTH-1:0] lfsr_next(
    input logic [c_MAX_WIDTH-1:0] state,
    input logic [c_MAX_WIDTH-1:0] taps,
    input logic                   mode,
    input int                     width
  );
    logic [c_MAX_WIDTH-1:0] w_sh;
    logic                   w_par;
    w_sh  = state >> 1;
    w_par = ^(state & taps);
    if (mode == MODE_FIB)
      w_sh = w_sh | ({{(c_MAX_WIDTH-1){1'b0}}, w_par} << (width - 1));
    else if (state[0])
      w_sh = w_sh ^ taps;
    return w_sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_seq_engine_if.sv
// ============================================================================
// lfsr_seq_engine_if
// Control/data bundle of the LFSR sequencer; period outputs under LFSR_PERIOD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lfsr_seq_engine_if #(
  parameter int WIDTH = 8
);
  logic             load_state;
  logic             load_taps;
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             run;
  logic             step;
  logic [WIDTH-1:0] state;
  logic             adv;
  logic             stuck;
`ifdef LFSR_PERIOD_EN
  logic [WIDTH:0]   period;
  logic             period_valid;

  modport master (
    output load_state, load_taps, data_in, mode, run, step,
    input  state, adv, stuck, period, period_valid
  );
  modport slave (
    input  load_state, load_taps, data_in, mode, run, step,
    output state, adv, stuck, period, period_valid
  );
`else
  modport master (
    output load_state, load_taps, data_in, mode, run, step,
    input  state, adv, stuck
  );
  modport slave (
    input  load_state, load_taps, data_in, mode, run, step,
    output state, adv, stuck
  );
`endif
endinterface

`default_nettype wire

// File: rtl/lfsr_seq_engine_prescaler.sv
// ============================================================================
// lfsr_seq_engine_prescaler
// Free-run step divider: fire once every TICKS_PER_STEP enabled cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr_seq_engine_prescaler #(
  parameter int TICKS_PER_STEP = 1000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic en,
  input  wire logic clr,
  output logic      fire
);

  localparam int c_CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICKS_PER_STEP - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (clr || !en || (r_cnt == c_LAST))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign fire = en & (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/lfsr_seq_engine.sv
// ============================================================================
// lfsr_seq_engine
// Programmable Galois/Fibonacci LFSR with prescaled free-run or single-step.
// Optional period measurement enabled by macro LFSR_PERIOD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr_seq_engine
  import lfsr_seq_engine_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TICKS_PER_STEP = 1000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  lfsr_seq_engine_if.slave   bus
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_taps;
  logic             r_adv;
  logic             r_step_q;
  logic             w_fire;
  logic             w_edge;
  logic             w_go;
  logic [WIDTH-1:0] w_next;

  lfsr_seq_engine_prescaler #(
    .TICKS_PER_STEP (TICKS_PER_STEP)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.run),
    .clr   (bus.load_state),
    .fire  (w_fire)
  );

  // Manual steps are ignored while free-running.
  assign w_edge = bus.step & ~r_step_q;
  assign w_go   = w_fire | (w_edge & ~bus.run);
  assign w_next = WIDTH'(lfsr_next(c_MAX_WIDTH'(r_state), c_MAX_WIDTH'(r_taps), bus.mode, WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WIDTH'(1);
      r_taps   <= '0;
      r_adv    <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= bus.step;
      r_adv    <= 1'b0;
      if (bus.load_state) begin
        r_state <= bus.data_in;
      end else if (w_go) begin
        r_state <= w_next;
        r_adv   <= 1'b1;
      end
      if (bus.load_taps)
        r_taps <= bus.data_in;
    end
  end

  assign bus.state = r_state;
  assign bus.adv   = r_adv;
  assign bus.stuck = (r_state == '0);

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH:0]   r_pcnt;
  logic [WIDTH:0]   r_period;
  logic             r_period_valid;

  // Once pcnt saturates the sequence never returned to the seed; stop counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed         <= '0;
      r_pcnt         <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else if (bus.load_state) begin
      r_seed         <= bus.data_in;
      r_pcnt         <= '0;
      r_period_valid <= 1'b0;
    end else if (w_go && (r_pcnt != '1)) begin
      if (w_next == r_seed) begin
        r_period       <= r_pcnt + 1'b1;
        r_period_valid <= 1'b1;
        r_pcnt         <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_seq_engine.sv
// ============================================================================
// tb_lfsr_seq_engine
// Scoreboard bench for lfsr_seq_engine at WIDTH=5, TICKS_PER_STEP=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_seq_engine;
  import lfsr_seq_engine_pkg::*;

  localparam int c_W = 5;
  localparam int c_T = 4;

  logic clk;
  logic reset;

  lfsr_seq_engine_if #(.WIDTH(c_W)) ifc ();

  lfsr_seq_engine #(
    .WIDTH          (c_W),
    .TICKS_PER_STEP (c_T)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             n_checks;
  int             n_errors;
  int             cyc;
  int             last_adv;
  int             adv_cnt;
  int             mark;
  logic [c_W-1:0] exp_q[$];
  logic [c_W-1:0] m_state;
  logic [c_W-1:0] m_taps;
  logic           m_mode;
  logic           chk_int;
  logic           chk_seen;
  logic           seen_zero;
  logic [31:0]    seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance the model once and queue the value the DUT must show with its adv pulse.
  task automatic push_adv();
    m_state = c_W'(lfsr_next(c_MAX_WIDTH'(m_state), c_MAX_WIDTH'(m_taps), m_mode, c_W));
    exp_q.push_back(m_state);
  endtask

  task automatic cycle();
    logic [c_W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.adv) begin
      adv_cnt++;
      if (chk_int) check("adv_interval", cyc - last_adv, c_T);
      last_adv = cyc;
      if (exp_q.size() == 0) begin
        check("adv_spurious", ifc.adv, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("adv_state", ifc.state, e);
        if (ifc.state == '0) seen_zero = 1'b1;
        if (chk_seen) seen[ifc.state] = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic load(input logic st, input logic tp, input logic [c_W-1:0] d);
    ifc.data_in    = d;
    ifc.load_state = st;
    ifc.load_taps  = tp;
    cycle();
    ifc.load_state = 1'b0;
    ifc.load_taps  = 1'b0;
    if (st) m_state = d;
    if (tp) m_taps  = d;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_adv = 0; adv_cnt = 0;
    chk_int = 1'b0; chk_seen = 1'b0; seen_zero = 1'b0; seen = '0;
    m_state = 1; m_taps = 0; m_mode = MODE_GALOIS;
    reset = 1'b1;
    ifc.load_state = 0; ifc.load_taps = 0; ifc.data_in = 0;
    ifc.mode = 0; ifc.run = 0; ifc.step = 0;
    repeat (2) cycle();
    check("rst_state", ifc.state, 1);
    check("rst_adv", ifc.adv, 0);
    check("rst_stuck", ifc.stuck, 0);
    reset = 1'b0;

    // Galois, taps 0x14, full maximal-length loop
    load(1'b0, 1'b1, 5'h14);
    ifc.run = 1'b1; ifc.mode = MODE_GALOIS; m_mode = MODE_GALOIS;
    load(1'b1, 1'b0, 5'h01);
    check("g_seed", ifc.state, 1);
    exp_q.push_back(5'h14); exp_q.push_back(5'h0A);
    exp_q.push_back(5'h05); exp_q.push_back(5'h16);
    m_state = 5'h16;
    repeat (27) push_adv();
    last_adv = cyc; chk_int = 1'b1; seen_zero = 1'b0;
    drain(31 * c_T + 8);
    chk_int = 1'b0; ifc.run = 1'b0;
    check("g_wrap", ifc.state, 1);
    check("g_no_zero", seen_zero, 0);

    // Fibonacci, taps 0x05
    load(1'b0, 1'b1, 5'h05);
    ifc.run = 1'b1; ifc.mode = MODE_FIB; m_mode = MODE_FIB;
    load(1'b1, 1'b0, 5'h01);
    repeat (31) push_adv();
    seen = '0; chk_seen = 1'b1;
    drain(31 * c_T + 8);
    chk_seen = 1'b0; ifc.run = 1'b0;
    check("f_distinct", $countones(seen), 31);
    check("f_no_zero", seen[0], 0);
    check("f_wrap", ifc.state, 1);

    // Single-step: three short pulses plus one long hold -> four advances
    adv_cnt = 0;
    repeat (3) begin
      ifc.step = 1'b1; push_adv();
      repeat (2) cycle();
      ifc.step = 1'b0;
      repeat (2) cycle();
    end
    ifc.step = 1'b1; push_adv();
    repeat (10) cycle();
    ifc.step = 1'b0;
    repeat (3) cycle();
    check("step_adv_count", adv_cnt, 4);
    check("step_q_empty", exp_q.size(), 0);

    // Lock-up at zero and recovery by load
    ifc.run = 1'b1;
    load(1'b1, 1'b0, 5'h00);
    check("zero_stuck", ifc.stuck, 1);
    check("zero_state", ifc.state, 0);
    repeat (5) push_adv();
    drain(5 * c_T + 8);
    check("zero_hold_stuck", ifc.stuck, 1);
    ifc.run = 1'b0;
    load(1'b1, 1'b0, 5'h03);
    check("recover_stuck", ifc.stuck, 0);
    check("recover_state", ifc.state, 3);

    // load_state colliding with fire
    ifc.mode = MODE_GALOIS; m_mode = MODE_GALOIS;
    ifc.run = 1'b1;
    push_adv();
    drain(c_T + 4);
    repeat (3) cycle();
    load(1'b1, 1'b0, 5'h0B);
    mark = cyc;
    check("collide_state", ifc.state, 5'h0B);
    check("collide_adv", ifc.adv, 0);
    push_adv();
    drain(c_T + 4);
    check("collide_gap", last_adv - mark, c_T);

    // Asynchronous reset mid-run
    repeat (2) cycle();
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", ifc.state, 1);
    check("async_rst_adv", ifc.adv, 0);
    #2 reset = 1'b0;
    mark = cyc;
    m_state = 1; m_taps = 0;
    push_adv();
    drain(c_T + 4);
    check("post_rst_gap", last_adv - mark, c_T);
    check("post_rst_stuck", ifc.stuck, 1);
    ifc.run = 1'b0;

`ifdef LFSR_PERIOD_EN
    load(1'b0, 1'b1, 5'h14);
    ifc.run = 1'b1;
    load(1'b1, 1'b0, 5'h01);
    check("per_clear", ifc.period_valid, 0);
    repeat (30) push_adv();
    drain(30 * c_T + 8);
    check("per_not_early", ifc.period_valid, 0);
    push_adv();
    drain(c_T + 4);
    check("per_valid", ifc.period_valid, 1);
    check("per_value", ifc.period, 31);
    ifc.run = 1'b0;
    load(1'b0, 1'b1, 5'h00);
    ifc.run = 1'b1;
    load(1'b1, 1'b0, 5'h01);
    repeat (10) push_adv();
    drain(10 * c_T + 8);
    check("per_drain_valid", ifc.period_valid, 0);
    check("per_drain_stuck", ifc.stuck, 1);
    ifc.run = 1'b0;
`endif

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
